// File: rtl/kc705_pkg.sv
// rtl/kc705_pkg.sv - shared state and reset-cause encodings for the KC705 reset conditioner
package kc705_pkg;

    typedef enum logic [1:0] {
        POR_HOLD = 2'd0,
        ASSERT   = 2'd1,
        RELEASE  = 2'd2,
        RUN      = 2'd3
    } rc_state_t;

    localparam logic [1:0] CAUSE_POR = 2'b00;
    localparam logic [1:0] CAUSE_BTN = 2'b01;
    localparam logic [1:0] CAUSE_EXT = 2'b10;

endpackage

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchroniser plus stability debouncer for board buttons and switches
module debounce_sync #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic press
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // The raw pin is only ever sampled as data; the idle level is released (1).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            cnt    <= '0;
            level  <= 1'b1;
            press  <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync_2;
                press <= level & ~sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/kc705_reset_conditioner.sv
// rtl/kc705_reset_conditioner.sv - conditions button and external requests into a held SoC reset
module kc705_reset_conditioner
    import kc705_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned HOLD_CYCLES     = 4096
) (
    input  logic       ref_clk,
    input  logic       rst,
    input  logic       pad_reset_n,
    input  logic       ext_hold_i,
    output logic       soc_reset_n_o,
    output logic [1:0] reset_cause_o,
    output logic [7:0] btn_reset_count_o,
    output logic       ready_o
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

    logic          btn_level;
    logic          btn_press;
    logic          cause_active;
    rc_state_t     state;
    logic [HW-1:0] hold_cnt;

    debounce_sync #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk  (ref_clk),
        .rst  (rst),
        .din  (pad_reset_n),
        .level(btn_level),
        .press(btn_press)
    );

    assign cause_active = ~btn_level | ext_hold_i;

    // soc_reset_n_o is written alongside every state transition so it always mirrors state == RUN.
    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state         <= POR_HOLD;
            hold_cnt      <= '0;
            soc_reset_n_o <= 1'b0;
            reset_cause_o <= CAUSE_POR;
            ready_o       <= 1'b0;
        end else begin
            case (state)
                POR_HOLD, RELEASE: begin
                    if (cause_active) begin
                        state         <= ASSERT;
                        hold_cnt      <= '0;
                        soc_reset_n_o <= 1'b0;
                        reset_cause_o <= btn_level ? CAUSE_EXT : CAUSE_BTN;
                    end else if (hold_cnt == HOLD_MAX) begin
                        state         <= RUN;
                        hold_cnt      <= '0;
                        soc_reset_n_o <= 1'b1;
                        ready_o       <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ASSERT: begin
                    hold_cnt      <= '0;
                    soc_reset_n_o <= 1'b0;
                    if (!cause_active) begin
                        state <= RELEASE;
                    end
                end
                RUN: begin
                    hold_cnt <= '0;
                    if (cause_active) begin
                        state         <= ASSERT;
                        soc_reset_n_o <= 1'b0;
                        reset_cause_o <= btn_level ? CAUSE_EXT : CAUSE_BTN;
                    end
                end
                default: begin
                    state         <= POR_HOLD;
                    hold_cnt      <= '0;
                    soc_reset_n_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            btn_reset_count_o <= 8'd0;
        end else if (btn_press && btn_reset_count_o != 8'hFF) begin
            btn_reset_count_o <= btn_reset_count_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_kc705_reset_conditioner.sv
// tb/tb_kc705_reset_conditioner.sv - directed self-checking bench for kc705_reset_conditioner
module tb_kc705_reset_conditioner;

    logic       ref_clk = 1'b0;
    logic       rst;
    logic       pad_reset_n;
    logic       ext_hold_i;
    logic       soc_reset_n_o;
    logic [1:0] reset_cause_o;
    logic [7:0] btn_reset_count_o;
    logic       ready_o;

    int checks = 0;
    int errors = 0;

    kc705_reset_conditioner #(
        .DEBOUNCE_CYCLES(8),
        .HOLD_CYCLES    (16)
    ) dut (
        .ref_clk          (ref_clk),
        .rst              (rst),
        .pad_reset_n      (pad_reset_n),
        .ext_hold_i       (ext_hold_i),
        .soc_reset_n_o    (soc_reset_n_o),
        .reset_cause_o    (reset_cause_o),
        .btn_reset_count_o(btn_reset_count_o),
        .ready_o          (ready_o)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    // Cycles until soc_reset_n_o reaches lvl; 999 when the budget expires.
    task automatic wait_soc(input logic lvl, output int n);
        n = 999;
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (soc_reset_n_o === lvl) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1; pad_reset_n = 1'b1; ext_hold_i = 1'b0;
        tick(3);
        checks++;
        if ({soc_reset_n_o, reset_cause_o, btn_reset_count_o, ready_o} !== 12'h000) begin
            errors++;
            $display("FAIL reset_values got soc=%b cause=%b cnt=%0d ready=%b want 0/00/0/0",
                     soc_reset_n_o, reset_cause_o, btn_reset_count_o, ready_o);
        end
        rst = 1'b0;
        wait_soc(1'b1, n);
        checks++;
        if (n !== 16) begin errors++; $display("FAIL por_release_latency got %0d want 16", n); end
        checks++;
        if (reset_cause_o !== 2'b00 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL por_cause_ready got cause=%b ready=%b want 00/1", reset_cause_o, ready_o);
        end
    endtask

    task automatic test_glitch;
        int lows = 0;
        pad_reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin tick(1); if (!soc_reset_n_o) lows++; end
        pad_reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin tick(1); if (!soc_reset_n_o) lows++; end
        checks++;
        if (lows !== 0) begin errors++; $display("FAIL glitch_ignored got %0d low cycles want 0", lows); end
        checks++;
        if (btn_reset_count_o !== 8'd0) begin
            errors++; $display("FAIL glitch_count got %0d want 0", btn_reset_count_o);
        end
    endtask

    task automatic test_button;
        int n;
        pad_reset_n = 1'b0;
        wait_soc(1'b0, n);
        checks++;
        if (n !== 11) begin errors++; $display("FAIL button_assert_latency got %0d want 11", n); end
        checks++;
        if (reset_cause_o !== 2'b01) begin errors++; $display("FAIL button_cause got %b want 01", reset_cause_o); end
        tick(19);
        checks++;
        if (btn_reset_count_o !== 8'd1) begin errors++; $display("FAIL button_count got %0d want 1", btn_reset_count_o); end
        pad_reset_n = 1'b1;
        wait_soc(1'b1, n);
        checks++;
        if (n !== 27) begin errors++; $display("FAIL button_release_latency got %0d want 27", n); end
        checks++;
        if (reset_cause_o !== 2'b01) begin errors++; $display("FAIL button_cause_held got %b want 01", reset_cause_o); end
    endtask

    task automatic test_simultaneous;
        int n;
        int highs = 0;
        pad_reset_n = 1'b0;
        tick(10);
        ext_hold_i = 1'b1;
        tick(1);
        checks++;
        if (soc_reset_n_o !== 1'b0 || reset_cause_o !== 2'b01) begin
            errors++;
            $display("FAIL simultaneous_cause got soc=%b cause=%b want 0/01", soc_reset_n_o, reset_cause_o);
        end
        ext_hold_i = 1'b0;
        for (int i = 0; i < 20; i++) begin tick(1); if (soc_reset_n_o) highs++; end
        checks++;
        if (highs !== 0) begin errors++; $display("FAIL ext_release_only got %0d high cycles want 0", highs); end
        pad_reset_n = 1'b1;
        wait_soc(1'b1, n);
        checks++;
        if (n !== 27 || btn_reset_count_o !== 8'd2) begin
            errors++;
            $display("FAIL simultaneous_release got lat=%0d cnt=%0d want 27/2", n, btn_reset_count_o);
        end
    endtask

    task automatic test_hold_restart;
        int n;
        ext_hold_i = 1'b1;
        tick(1);
        ext_hold_i = 1'b0;
        tick(11);
        checks++;
        if (soc_reset_n_o !== 1'b0) begin errors++; $display("FAIL release_hold_low got %b want 0", soc_reset_n_o); end
        ext_hold_i = 1'b1;
        tick(1);
        checks++;
        if (reset_cause_o !== 2'b10) begin errors++; $display("FAIL ext_cause got %b want 10", reset_cause_o); end
        ext_hold_i = 1'b0;
        wait_soc(1'b1, n);
        checks++;
        if (n !== 17) begin errors++; $display("FAIL hold_restart_latency got %0d want 17", n); end
    endtask

    task automatic test_saturation;
        int n;
        for (int p = 1; p <= 300; p++) begin
            pad_reset_n = 1'b0; tick(12);
            pad_reset_n = 1'b1; tick(12);
            if (p == 100) begin
                checks++;
                if (btn_reset_count_o !== 8'd102) begin
                    errors++; $display("FAIL count_mid got %0d want 102", btn_reset_count_o);
                end
            end
        end
        tick(5);
        checks++;
        if (btn_reset_count_o !== 8'd255) begin errors++; $display("FAIL count_saturate got %0d want 255", btn_reset_count_o); end
        pad_reset_n = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(1);
        checks++;
        if ({soc_reset_n_o, reset_cause_o, btn_reset_count_o, ready_o} !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid_press got soc=%b cause=%b cnt=%0d ready=%b want 0/00/0/0",
                     soc_reset_n_o, reset_cause_o, btn_reset_count_o, ready_o);
        end
        pad_reset_n = 1'b1;
        rst = 1'b0;
        wait_soc(1'b1, n);
        checks++;
        if (n !== 16 || ready_o !== 1'b1 || btn_reset_count_o !== 8'd0) begin
            errors++;
            $display("FAIL post_rst_release got lat=%0d ready=%b cnt=%0d want 16/1/0", n, ready_o, btn_reset_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_button();
        test_simultaneous();
        test_hold_restart();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
